axi_wr_slave_bridge: RTL and testbench



---
 rtl/axi_wr_slave_bridge_pkg.sv | 35 +++
 rtl/axi_wr_slave_bridge_if.sv | 47 ++++
 rtl/axi_wr_slave_bridge_sync_fifo.sv | 63 ++++++
 rtl/axi_wr_slave_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_wr_slave_bridge.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wr_slave_bridge_pkg.sv
// Shared types and default widths for the AXI write-channel slave of the AXI-to-I2C bridge.
// Optional build macro: AXI_WR_STRB_EN (adds WSTRB / cmd_strb byte strobes).
package axi_i2c_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned LEN_W          = 8;
  localparam int unsigned SIZE_W         = 3;
  localparam int unsigned BURST_W        = 2;
  localparam int unsigned CNT_W          = 9;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT_RSP,
    RESP
  } wr_state_t;

  // Largest AWSIZE a data bus of the given width can carry.
  function automatic logic [SIZE_W-1:0] max_size(input int unsigned data_width);
    return SIZE_W'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_wr_slave_bridge_if.sv
// AXI write address / data / response channels as seen by the bridge.
// Optional build macro: AXI_WR_STRB_EN (adds WSTRB).
interface axi_wr_slave_bridge_if
  import axi_i2c_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [LEN_W-1:0]        AWLEN;
  logic [SIZE_W-1:0]       AWSIZE;
  logic [BURST_W-1:0]      AWBURST;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic                    WLAST;
`ifdef AXI_WR_STRB_EN
  logic [DATA_WIDTH/8-1:0] WSTRB;
`endif
  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
    output WVALID, WDATA, WLAST,
`ifdef AXI_WR_STRB_EN
    output WSTRB,
`endif
    output BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
    input  WVALID, WDATA, WLAST,
`ifdef AXI_WR_STRB_EN
    input  WSTRB,
`endif
    input  BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/axi_wr_slave_bridge_sync_fifo.sv
// Single-clock FIFO with registered flags and a one-cycle lookahead full indication.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_full_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_count_nxt;

  // Pop needs data; push into a full FIFO is only allowed when a pop frees a slot.
  assign w_pop        = i_pop && !r_empty;
  assign w_push       = i_push && (!r_full || w_pop);
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign o_full_nxt_c = (w_count_nxt == CNT_W'(DEPTH));

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= o_full_nxt_c;
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array; contents need no reset because the flags gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/axi_wr_slave_bridge.sv
// AXI write-channel slave: takes one AW + W burst at a time, queues per-beat
// {addr, data, last} commands for the I2C engine and returns one B per burst.
// Optional build macro: AXI_WR_STRB_EN (WSTRB in, cmd_strb out; all-zero strobe beats are dropped).
module axi_wr_slave_bridge
  import axi_i2c_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  axi_wr_slave_bridge_if.slave    s_axi,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    cmd_last,
`ifdef AXI_WR_STRB_EN
  output logic [DATA_WIDTH/8-1:0] cmd_strb,
`endif
  input  logic                    rsp_valid,
  input  logic                    rsp_nack
);

  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam logic [SIZE_W-1:0] MAX_SIZE_L = max_size(DATA_WIDTH);
`ifdef AXI_WR_STRB_EN
  localparam int unsigned FIFO_W     = ADDR_WIDTH + DATA_WIDTH + 1 + STRB_W;
`else
  localparam int unsigned FIFO_W     = ADDR_WIDTH + DATA_WIDTH + 1;
`endif

  wr_state_t             r_state;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  resp_t                 r_bresp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [SIZE_W-1:0]     r_size;
  logic                  r_incr;
  logic                  r_legal;
  logic                  r_err;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [CNT_W-1:0]      r_push_cnt;
  logic [CNT_W-1:0]      r_rsp_cnt;

  wr_state_t             w_state_nxt;
  logic                  w_awready_nxt;
  logic                  w_wready_nxt;
  logic                  w_bvalid_nxt;
  resp_t                 w_bresp_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [LEN_W-1:0]      w_len_nxt;
  logic [SIZE_W-1:0]     w_size_nxt;
  logic                  w_incr_nxt;
  logic                  w_legal_nxt;
  logic                  w_err_nxt;
  logic [CNT_W-1:0]      w_beat_nxt;
  logic [CNT_W-1:0]      w_push_cnt_nxt;
  logic [CNT_W-1:0]      w_rsp_cnt_nxt;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_legal;
  logic                  w_strb_ok;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rsp_acc;
  logic [CNT_W-1:0]      w_len_p1;
  logic [FIFO_W-1:0]     w_fifo_wdata;
  logic [FIFO_W-1:0]     w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_fifo_full_nxt;

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;

  // Channel handshakes; the full term is a guard, WREADY is already low when full.
  assign w_aw_hs = (r_state == IDLE) && r_awready && s_axi.AWVALID;
  assign w_w_hs  = (r_state == DATA) && r_wready && s_axi.WVALID && !w_fifo_full;

  // A burst is serviceable only for FIXED/INCR with a size that fits the data bus.
  assign w_aw_legal = ((s_axi.AWBURST == FIXED) || (s_axi.AWBURST == INCR)) &&
                      (s_axi.AWSIZE <= MAX_SIZE_L);

`ifdef AXI_WR_STRB_EN
  assign w_strb_ok    = |s_axi.WSTRB;
  assign w_fifo_wdata = {r_addr, s_axi.WDATA, s_axi.WLAST, s_axi.WSTRB};
  assign {cmd_addr, cmd_data, cmd_last, cmd_strb} = w_fifo_rdata;
`else
  assign w_strb_ok    = 1'b1;
  assign w_fifo_wdata = {r_addr, s_axi.WDATA, s_axi.WLAST};
  assign {cmd_addr, cmd_data, cmd_last} = w_fifo_rdata;
`endif

  assign w_push    = w_w_hs && r_legal && w_strb_ok;
  assign cmd_valid = !w_fifo_empty;
  assign w_pop     = cmd_valid && cmd_ready;
  assign w_len_p1  = CNT_W'(r_len) + CNT_W'(1);

  // Engine results count only while beats can be outstanding; surplus pulses are dropped.
  assign w_rsp_acc = ((r_state == DATA) || (r_state == WAIT_RSP)) && rsp_valid &&
                     (r_rsp_cnt != r_push_cnt);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk          (ACLK),
    .rst_n        (ARESETn),
    .i_push       (w_push),
    .i_wdata      (w_fifo_wdata),
    .i_pop        (w_pop),
    .o_rdata      (w_fifo_rdata),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_full_nxt_c (w_fifo_full_nxt)
  );

  // Next state, burst bookkeeping and next values of the registered channel outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_len_nxt      = r_len;
    w_size_nxt     = r_size;
    w_incr_nxt     = r_incr;
    w_legal_nxt    = r_legal;
    w_err_nxt      = r_err;
    w_beat_nxt     = r_beat_cnt;
    w_push_cnt_nxt = r_push_cnt;
    w_rsp_cnt_nxt  = r_rsp_cnt;
    w_awready_nxt  = 1'b0;
    w_wready_nxt   = 1'b0;
    w_bvalid_nxt   = 1'b0;
    w_bresp_nxt    = OKAY;

    case (r_state)
      IDLE: begin
        if (w_aw_hs) begin
          w_addr_nxt     = s_axi.AWADDR;
          w_len_nxt      = s_axi.AWLEN;
          w_size_nxt     = s_axi.AWSIZE;
          w_incr_nxt     = (s_axi.AWBURST == INCR);
          w_legal_nxt    = w_aw_legal;
          w_err_nxt      = 1'b0;
          w_beat_nxt     = '0;
          w_push_cnt_nxt = '0;
          w_rsp_cnt_nxt  = '0;
          w_state_nxt    = DATA;
        end
      end
      DATA: begin
        if (w_w_hs) begin
          w_beat_nxt = r_beat_cnt + CNT_W'(1);
          if (w_push) w_push_cnt_nxt = r_push_cnt + CNT_W'(1);
          if (!r_legal) w_err_nxt = 1'b1;
          if (r_incr) w_addr_nxt = r_addr + (ADDR_WIDTH'(1) << r_size);
          if (s_axi.WLAST) begin
            if (w_beat_nxt != w_len_p1) w_err_nxt = 1'b1;
            w_state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (r_rsp_cnt == r_push_cnt) w_state_nxt = RESP;
      end
      RESP: begin
        if (s_axi.BREADY && r_bvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_rsp_acc) begin
      w_rsp_cnt_nxt = r_rsp_cnt + CNT_W'(1);
      if (rsp_nack) w_err_nxt = 1'b1;
    end

    w_awready_nxt = (w_state_nxt == IDLE);
    w_wready_nxt  = (w_state_nxt == DATA) && !w_fifo_full_nxt;
    w_bvalid_nxt  = (w_state_nxt == RESP);
    if ((w_state_nxt == RESP) && w_err_nxt) w_bresp_nxt = SLVERR;
  end

  // State, burst context and registered channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_incr     <= 1'b0;
      r_legal    <= 1'b0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
      r_push_cnt <= '0;
      r_rsp_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_bresp    <= w_bresp_nxt;
      r_addr     <= w_addr_nxt;
      r_len      <= w_len_nxt;
      r_size     <= w_size_nxt;
      r_incr     <= w_incr_nxt;
      r_legal    <= w_legal_nxt;
      r_err      <= w_err_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_push_cnt <= w_push_cnt_nxt;
      r_rsp_cnt  <= w_rsp_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_bridge.sv
// Directed bench for axi_wr_slave_bridge: table of bursts plus hand-written
// FIFO-full and mid-burst reset sequences. A small engine model pops commands
// and returns one ACK/NACK pulse per popped beat.
module tb_axi_wr_slave_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 8;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  axi_wr_slave_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          cmd_last;
  logic          rsp_valid;
  logic          rsp_nack;
`ifdef AXI_WR_STRB_EN
  logic [DW/8-1:0] cmd_strb;
`endif

  axi_wr_slave_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .s_axi     (axi),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
`ifdef AXI_WR_STRB_EN
    .cmd_strb  (cmd_strb),
`endif
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    int               nbeats;
    logic [3:0]       nack;
    int               exp_push;
    logic [3:0][31:0] exp_addr;
    logic [3:0]       exp_last;
    logic [1:0]       exp_resp;
  } vec_t;

  vec_t vecs[8];

  // Engine model state
  logic        eng_ready = 1'b0;
  logic [15:0] eng_nack  = '0;
  int          eng_idx   = 0;
  logic        pend_rsp  = 1'b0;
  logic        pend_nack = 1'b0;
  logic [31:0] rec_addr[$];
  logic [31:0] rec_data[$];
  logic        rec_last[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic to_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake never came within the cycle budget", name);
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int nbeats, input logic [3:0] nack,
                              input int exp_push, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3, input logic [3:0] last,
                              input logic [1:0] resp);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.nbeats = nbeats;
    v.nack = nack; v.exp_push = exp_push; v.exp_last = last; v.exp_resp = resp;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  function automatic logic [31:0] beat_data(input int vi, input int i);
    return 32'(32'hA0 + (vi << 8) + i);
  endfunction

  // Engine: pops whenever eng_ready, answers each popped beat one cycle later.
  initial begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        pend_rsp  = 1'b0;
        pend_nack = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        cmd_ready = 1'b0;
      end else begin
        rsp_valid = pend_rsp;
        rsp_nack  = pend_nack;
        pend_rsp  = 1'b0;
        pend_nack = 1'b0;
        cmd_ready = eng_ready;
        if (cmd_valid && cmd_ready) begin
          rec_addr.push_back(cmd_addr);
          rec_data.push_back(cmd_data);
          rec_last.push_back(cmd_last);
          pend_rsp  = 1'b1;
          pend_nack = eng_nack[eng_idx[3:0]];
          eng_idx++;
        end
      end
    end
  end

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input string tag);
    int n = 0;
    axi.AWADDR  = addr;
    axi.AWLEN   = len;
    axi.AWSIZE  = size;
    axi.AWBURST = burst;
    axi.AWVALID = 1'b1;
    while (!axi.AWREADY && n < 100) begin @(negedge ACLK); n++; end
    if (!axi.AWREADY) begin to_fail(tag); axi.AWVALID = 1'b0; return; end
    @(negedge ACLK);
    axi.AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic last, input string tag);
    int n = 0;
    axi.WVALID = 1'b1;
    axi.WDATA  = data;
    axi.WLAST  = last;
    while (!axi.WREADY && n < 100) begin @(negedge ACLK); n++; end
    if (!axi.WREADY) begin
      to_fail(tag);
      axi.WVALID = 1'b0;
      axi.WLAST  = 1'b0;
      return;
    end
    @(negedge ACLK);
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
  endtask

  // Waits for B, checks it is held, completes the handshake and checks return to IDLE.
  task automatic b_phase(input string tag, input logic [1:0] exp_resp, output int cyc);
    cyc = 0;
    while (!axi.BVALID && cyc < 500) begin @(negedge ACLK); cyc++; end
    if (!axi.BVALID) begin to_fail({tag, "_bvalid"}); return; end
    check({tag, "_bresp"}, 32'(axi.BRESP), 32'(exp_resp));
    @(negedge ACLK);
    check({tag, "_bhold"}, 32'({axi.BVALID, axi.BRESP}), 32'({1'b1, exp_resp}));
    check({tag, "_awready_in_resp"}, 32'(axi.AWREADY), 32'd0);
    axi.BREADY = 1'b1;
    @(negedge ACLK);
    axi.BREADY = 1'b0;
    check({tag, "_bvalid_clear"}, 32'(axi.BVALID), 32'd0);
    check({tag, "_awready_idle"}, 32'(axi.AWREADY), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int    cyc;
    string tag;
    tag = $sformatf("v%0d", vi);
    rec_addr.delete();
    rec_data.delete();
    rec_last.delete();
    eng_idx   = 0;
    eng_nack  = 16'(v.nack);
    eng_ready = 1'b1;
    aw_send(v.addr, v.len, v.size, v.burst, {tag, "_aw"});
    for (int i = 0; i < v.nbeats; i++)
      w_send(beat_data(vi, i), (i == v.nbeats - 1), $sformatf("%s_w%0d", tag, i));
    b_phase(tag, v.exp_resp, cyc);
    if (v.exp_push == 0) check({tag, "_b_latency"}, 32'(cyc), 32'd1);
    check({tag, "_npushed"}, 32'(rec_addr.size()), 32'(v.exp_push));
    for (int i = 0; i < v.exp_push && i < rec_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), rec_addr[i], v.exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), rec_data[i], beat_data(vi, i));
      check($sformatf("%s_last%0d", tag, i), 32'(rec_last[i]), 32'(v.exp_last[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    ARESETn     = 1'b0;
    axi.AWVALID = 1'b0;
    axi.AWADDR  = '0;
    axi.AWLEN   = '0;
    axi.AWSIZE  = '0;
    axi.AWBURST = '0;
    axi.WVALID  = 1'b0;
    axi.WDATA   = '0;
    axi.WLAST   = 1'b0;
    axi.BREADY  = 1'b0;
`ifdef AXI_WR_STRB_EN
    axi.WSTRB   = '1;
`endif

    //             addr          len size burst nb nack push a0            a1            a2       a3       last     resp
    vecs[0] = mk(32'h0000_0100, 3, 2, 2'b01, 4, 4'b0000, 4, 32'h100,      32'h104,      32'h108, 32'h10C, 4'b1000, 2'b00);
    vecs[1] = mk(32'h0000_0040, 1, 2, 2'b00, 2, 4'b0010, 2, 32'h40,       32'h40,       32'h0,   32'h0,   4'b0010, 2'b10);
    vecs[2] = mk(32'h0000_0080, 2, 2, 2'b10, 3, 4'b0000, 0, 32'h0,        32'h0,        32'h0,   32'h0,   4'b0000, 2'b10);
    vecs[3] = mk(32'h0000_0200, 3, 2, 2'b01, 2, 4'b0000, 2, 32'h200,      32'h204,      32'h0,   32'h0,   4'b0010, 2'b10);
    vecs[4] = mk(32'hFFFF_FFFC, 1, 2, 2'b01, 2, 4'b0000, 2, 32'hFFFFFFFC, 32'h0,        32'h0,   32'h0,   4'b0010, 2'b00);
    vecs[5] = mk(32'h0000_0010, 2, 1, 2'b01, 3, 4'b0000, 3, 32'h10,       32'h12,       32'h14,  32'h0,   4'b0100, 2'b00);
    vecs[6] = mk(32'h0000_0020, 0, 3, 2'b01, 1, 4'b0000, 0, 32'h0,        32'h0,        32'h0,   32'h0,   4'b0000, 2'b10);
    vecs[7] = mk(32'h0000_0300, 0, 0, 2'b01, 1, 4'b0000, 1, 32'h300,      32'h0,        32'h0,   32'h0,   4'b0001, 2'b00);

    // Reset values
    repeat (3) @(negedge ACLK);
    check("rst_awready",   32'(axi.AWREADY), 32'd0);
    check("rst_wready",    32'(axi.WREADY),  32'd0);
    check("rst_bvalid",    32'(axi.BVALID),  32'd0);
    check("rst_bresp",     32'(axi.BRESP),   32'd0);
    check("rst_cmd_valid", 32'(cmd_valid),   32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst_awready_rise", 32'(axi.AWREADY), 32'd1);

    // Table of bursts
    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // FIFO fills with the engine stalled, then drains in order
    eng_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    rec_addr.delete();
    rec_data.delete();
    rec_last.delete();
    eng_idx  = 0;
    eng_nack = '0;
    aw_send(32'h0000_1000, 8'd15, 3'd2, 2'b01, "full_aw");
    for (int i = 0; i < 8; i++) w_send(32'(32'hB00 + i), 1'b0, $sformatf("full_w%0d", i));
    check("full_wready_low", 32'(axi.WREADY), 32'd0);
    check("full_cmd_valid",  32'(cmd_valid),  32'd1);
    repeat (3) @(negedge ACLK);
    check("full_wready_held", 32'(axi.WREADY), 32'd0);
    check("full_no_pops",     32'(rec_addr.size()), 32'd0);
    eng_ready = 1'b1;
    for (int i = 8; i < 16; i++) w_send(32'(32'hB00 + i), (i == 15), $sformatf("full_w%0d", i));
    b_phase("full", 2'b00, cyc);
    check("full_npushed", 32'(rec_addr.size()), 32'd16);
    for (int i = 0; i < 16 && i < rec_addr.size(); i++) begin
      check($sformatf("full_addr%0d", i), rec_addr[i], 32'(32'h1000 + 4 * i));
      check($sformatf("full_data%0d", i), rec_data[i], 32'(32'hB00 + i));
      check($sformatf("full_last%0d", i), 32'(rec_last[i]), 32'(i == 15));
    end

    // Reset in the middle of a burst with three beats queued
    eng_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    rec_addr.delete();
    rec_data.delete();
    rec_last.delete();
    aw_send(32'h0000_0500, 8'd7, 3'd2, 2'b01, "mid_aw");
    for (int i = 0; i < 3; i++) w_send(32'(32'hC00 + i), 1'b0, $sformatf("mid_w%0d", i));
    check("mid_cmd_valid_before", 32'(cmd_valid), 32'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    check("mid_cmd_valid_rst", 32'(cmd_valid),    32'd0);
    check("mid_bvalid_rst",    32'(axi.BVALID),   32'd0);
    check("mid_wready_rst",    32'(axi.WREADY),   32'd0);
    check("mid_awready_rst",   32'(axi.AWREADY),  32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("mid_no_stray_b", 32'(axi.BVALID), 32'd0);
    run_vec(vecs[0], 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
